sram_responder: RTL
===================

# sram_responder

Synchronous word-addressed SRAM responder that sits on the far side of the CPU's instruction-memory and data-memory ports. The CPU drives address, write data, active-low write strobe and active-low bit-write mask; this block returns registered read data one cycle later. One instance serves IM, one serves DM. It adds three things around the array: a power-on zero-scrub, a valid/ready backdoor preload port for test images, and saturating read/write access counters.

## Interface
Parameters:
- ADDR_W, 14, word-address width; depth = 2**ADDR_W words of 32 bits
- SCRUB_EN, 1, when 1, memory is zeroed after reset; when 0, the scrub is skipped

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- addr  in  ADDR_W  word address from CPU (im_addr / dm_addr)
- data_in  in  32  write data from CPU
- web  in  1  active-low write enable; 1 = read cycle
- bweb  in  32  active-low per-bit write mask; bit i = 0 writes bit i
- data_out  out  32  registered read data (im_instr / dm_data_out)
- ready  out  1  1 once scrub is complete and block is in RUN
- ld_valid  in  1  preload request
- ld_addr  in  ADDR_W  preload word address
- ld_data  in  32  preload word, full 32-bit write
- ld_ready  out  1  preload accept; combinational = ready & web
- rd_cnt  out  32  count of CPU read cycles in RUN, saturating
- wr_cnt  out  32  count of CPU write cycles in RUN, saturating

## Operation
- States: SCRUB and RUN. While rst = 0, the block is held in SCRUB with scrub counter 0, or in RUN if SCRUB_EN = 0.
- Reset values: data_out = 0, ready = 0, rd_cnt = 0, wr_cnt = 0, scrub counter = 0. Array contents are not reset by rst.
- SCRUB: each edge writes 0 to mem[scrub_cnt], then scrub_cnt += 1. The edge that writes word depth-1 moves the block to RUN and sets ready = 1.
- SCRUB cycles: CPU writes are ignored, data_out is loaded with 0, counters hold, and ld_ready = 0.
- RUN read (web = 1): data_out <= mem[addr]; rd_cnt += 1.
- RUN write (web = 0): mem[addr] <= (mem[addr] & bweb) | (data_in & ~bweb); data_out holds its previous value; wr_cnt += 1.
- bweb = all ones with web = 0 is a null write; it still counts in wr_cnt.
- Preload: the handshake is ld_valid & ld_ready, which writes mem[ld_addr] <= ld_data. A CPU write blocks preload (ld_ready = 0 when web = 0).
- Preload and a CPU read in the same cycle are both performed. If ld_addr == addr, data_out returns the old word (read-first).
- Counters saturate at 0xFFFF_FFFF and do not wrap.
- Reset mid-scrub or mid-run: the block aborts immediately. After rst is released, scrub restarts from word 0.

## Timing
- Read latency is 1: an address presented in cycle N appears on data_out after edge N and is stable through cycle N+1.
- Write latency is 1: the written word is readable from an address presented in cycle N+1.
- A read of the same address in cycle N+1 returns the merged word after edge N+1.
- ready rises after exactly depth rising edges following rst release when SCRUB_EN = 1, and after 1 edge when SCRUB_EN = 0.
- The preload write takes effect on the accepting edge.
- ld_ready has a combinational path from web only.

## Test plan
- ADDR_W = 4, SCRUB_EN = 1, array prefilled with 0xDEADBEEF via backdoor, release rst -> ready = 0 for 16 edges, then 1; a read of each address returns 0.
- RUN: write addr 3 with data 0x12345678 and bweb 0xFFFF0000, over an old value of 0xAAAAAAAA -> the next-cycle read of addr 3 gives data_out = 0xAAAA5678 one cycle later; wr_cnt = 1, rd_cnt = 1.
- Preload ld_addr 5 with ld_data 0xCAFEF00D while the CPU reads addr 5 in the same cycle -> data_out = old value; the next read gives 0xCAFEF00D. With web = 0 held, ld_ready = 0 and no write occurs.
- Write cycle following a read -> data_out keeps the prior read value during and after the write edge.
- Assert rst at scrub word 7, then release -> ready stays 0 for 16 more edges; words 0..15 all read 0 afterward.
- Force rd_cnt to 0xFFFFFFFE, then do 3 reads -> rd_cnt = 0xFFFFFFFF and holds.

Source files
------------

// File: rtl/sram_responder.sv
// Word-addressed 32-bit SRAM responder for the CPU IM/DM ports.
// Adds power-on zero-scrub, a valid/ready preload port and saturating access counters.
module sram_responder #(
    parameter int ADDR_W   = 14,
    parameter bit SCRUB_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    input  logic              web,
    input  logic [31:0]       bweb,
    output logic [31:0]       data_out,
    output logic              ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        SCRUB,
        RUN
    } state_t;

    localparam state_t RST_STATE = SCRUB_EN ? SCRUB : RUN;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] scrub_cnt;
    logic [31:0]       mem [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic [31:0]       wmask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (state == SCRUB && scrub_cnt == '1) begin
            state_nx = RUN;
        end
    end

    // One shared write port: scrub, CPU write and preload never overlap.
    always_comb begin
        ld_ready = ready & web;
        we       = 1'b0;
        waddr    = addr;
        wdata    = data_in;
        wmask    = ~bweb;
        unique case (1'b1)
            (state == SCRUB): begin
                we    = 1'b1;
                waddr = scrub_cnt;
                wdata = '0;
                wmask = '1;
            end
            (ready && !web): begin
                we = 1'b1;
            end
            (ld_valid && ld_ready): begin
                we    = 1'b1;
                waddr = ld_addr;
                wdata = ld_data;
                wmask = '1;
            end
            default: begin
                we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && we) begin
            mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= '0;
            ready     <= 1'b0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            scrub_cnt <= '0;
        end else begin
            ready <= (state_nx == RUN);
            if (state == SCRUB) begin
                scrub_cnt <= scrub_cnt + 1'b1;
                data_out  <= '0;
            end else if (ready) begin
                if (web) begin
                    data_out <= mem[addr];
                    if (rd_cnt != '1) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end else if (wr_cnt != '1) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

endmodule
